// File: rtl/adc_acq_ctrl.sv
// adc_acq_ctrl: acquisition sequencer between the Zmod scope sample stream and
// an AXI-Stream consumer. It waits for init, arms on request, optionally waits
// for a channel-1 level crossing, then forwards exactly record_len samples as
// one AXIS packet ending in TLAST. The ADC stream is never stalled. A sample
// that cannot be accepted downstream is dropped and flagged in o_overflow.
//
// Optional feature macro: ADC_ACQ_TRIGGER_EN
//   defined   : level trigger on ch1 (i_trig_level / i_trig_slope used)
//   undefined : ARMED lasts one cycle, capture starts with the first valid sample
//
// Ports:
//   i_sys_clock, i_reset          clock, async active-high reset
//   i_init_done                   ADC / relay init complete
//   i_arm, i_abort                single-cycle requests (abort wins)
//   i_record_len                  samples per record, latched on accepted arm
//   i_trig_level, i_trig_slope    signed threshold, 0 = rising / 1 = falling
//   i_adc_data, i_adc_data_valid  ADC stream in; o_adc_ready is constant 1
//   o_m_axis_*, i_m_axis_tready   AXIS master out
//   o_busy, o_done, o_overflow    status; o_state is the state encoding
module adc_acq_ctrl #(
  parameter int unsigned ZMOD_DATA_SIZE = 14,
  parameter int unsigned AXIS_DATA_SIZE = 32,
  parameter int unsigned LEN_WIDTH      = 16
) (
  input  logic                      i_sys_clock,
  input  logic                      i_reset,
  input  logic                      i_init_done,
  input  logic                      i_arm,
  input  logic                      i_abort,
  input  logic [LEN_WIDTH-1:0]      i_record_len,
  input  logic [ZMOD_DATA_SIZE-1:0] i_trig_level,
  input  logic                      i_trig_slope,
  input  logic [AXIS_DATA_SIZE-1:0] i_adc_data,
  input  logic                      i_adc_data_valid,
  output logic                      o_adc_ready,
  output logic [AXIS_DATA_SIZE-1:0] o_m_axis_tdata,
  output logic                      o_m_axis_tvalid,
  output logic                      o_m_axis_tlast,
  input  logic                      i_m_axis_tready,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_overflow,
  output logic [2:0]                o_state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_INIT = 3'd1,
    ST_ARMED     = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_FLUSH     = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [AXIS_DATA_SIZE-1:0] tdata_q, tdata_d;
  logic                      tvalid_q, tvalid_d;
  logic                      tlast_q, tlast_d;
  logic                      done_q, done_d;
  logic                      ovf_q, ovf_d;
  logic                      busy_q, busy_d;
  logic                      aborted_q, aborted_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic [LEN_WIDTH-1:0]      count_q, count_d;

  logic fire_c;
  logic stop_c;
  logic arm_ok_c;
  logic last_load_c;
  logic load_c;
  logic trig_hit_c;

  // Output beat handshake, and conditions that end loading early
  assign fire_c   = tvalid_q & i_m_axis_tready;
  assign stop_c   = i_abort |
                    (~i_init_done & ((state_q == ST_ARMED) | (state_q == ST_CAPTURE)));
  assign arm_ok_c = (state_q == ST_IDLE) & i_arm & ~i_abort & (i_record_len != '0);
  // Compare against len-1 so a full-scale length never needs a wider counter
  assign last_load_c = (count_q == LEN_WIDTH'(len_q - LEN_WIDTH'(1)));

`ifdef ADC_ACQ_TRIGGER_EN
  logic signed [ZMOD_DATA_SIZE-1:0] level_q, level_d;
  logic signed [ZMOD_DATA_SIZE-1:0] prev_q, prev_d;
  logic                             slope_q, slope_d;
  logic                             seeded_q, seeded_d;
  logic signed [ZMOD_DATA_SIZE-1:0] ch1_c;

  assign ch1_c = $signed(i_adc_data[31 -: ZMOD_DATA_SIZE]);

  // Crossing detector; the first sample after arming only seeds prev
  always_comb begin
    trig_hit_c = 1'b0;
    if (seeded_q) begin
      if (slope_q) trig_hit_c = (prev_q > level_q) && (ch1_c <= level_q);
      else         trig_hit_c = (prev_q < level_q) && (ch1_c >= level_q);
    end
  end

  // Trigger configuration and previous-sample tracking
  always_comb begin
    level_d  = level_q;
    slope_d  = slope_q;
    prev_d   = prev_q;
    seeded_d = seeded_q;
    if (arm_ok_c) begin
      level_d  = $signed(i_trig_level);
      slope_d  = i_trig_slope;
      seeded_d = 1'b0;
    end else if ((state_q == ST_ARMED) && i_adc_data_valid) begin
      prev_d   = ch1_c;
      seeded_d = 1'b1;
    end
  end

  always_ff @(posedge i_sys_clock or posedge i_reset) begin
    if (i_reset) begin
      level_q  <= '0;
      prev_q   <= '0;
      slope_q  <= 1'b0;
      seeded_q <= 1'b0;
    end else begin
      level_q  <= level_d;
      prev_q   <= prev_d;
      slope_q  <= slope_d;
      seeded_q <= seeded_d;
    end
  end
`else
  logic unused_trig;

  // Without the trigger every valid sample in ARMED starts the record
  assign trig_hit_c  = 1'b1;
  assign unused_trig = ^{i_trig_level, i_trig_slope};
`endif

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    len_d     = len_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    aborted_d = aborted_q;
    done_d    = 1'b0;
    load_c    = 1'b0;

    // An accepted beat frees the output register; a load below may refill it
    if (fire_c) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (arm_ok_c) begin
          state_d   = ST_WAIT_INIT;
          len_d     = i_record_len;
          count_d   = '0;
          ovf_d     = 1'b0;
          aborted_d = 1'b0;
        end
      end
      ST_WAIT_INIT: begin
        if (i_abort)          state_d = ST_IDLE;
        else if (i_init_done) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (stop_c) begin
          state_d = ST_IDLE;
        end else if (i_adc_data_valid && trig_hit_c) begin
          load_c = 1'b1;
        end
`ifndef ADC_ACQ_TRIGGER_EN
        else begin
          state_d = ST_CAPTURE;
        end
`endif
      end
      ST_CAPTURE: begin
        if (stop_c) begin
          // A pending beat must stay valid until taken, without tlast
          if (tvalid_q && !i_m_axis_tready) begin
            state_d   = ST_FLUSH;
            aborted_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (i_adc_data_valid) begin
          if (!tvalid_q || i_m_axis_tready) load_c = 1'b1;
          else                              ovf_d  = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (i_abort) aborted_d = 1'b1;
        if (fire_c) begin
          state_d = ST_IDLE;
          done_d  = ~(aborted_q | i_abort);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_c) begin
      tdata_d  = i_adc_data;
      tvalid_d = 1'b1;
      tlast_d  = last_load_c;
      count_d  = LEN_WIDTH'(count_q + LEN_WIDTH'(1));
      state_d  = last_load_c ? ST_FLUSH : ST_CAPTURE;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge i_sys_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      aborted_q <= 1'b0;
      len_q     <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      aborted_q <= aborted_d;
      len_q     <= len_d;
      count_q   <= count_d;
    end
  end

  assign o_adc_ready     = 1'b1;
  assign o_m_axis_tdata  = tdata_q;
  assign o_m_axis_tvalid = tvalid_q;
  assign o_m_axis_tlast  = tlast_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_overflow      = ovf_q;
  assign o_state         = state_q;

endmodule

// File: tb/tb_adc_acq_ctrl.sv
// Bench for adc_acq_ctrl: a sample/slot-level reference model checked every
// cycle, plus literal per-scenario expectations of the accepted beats.
module tb_adc_acq_ctrl;

  localparam int unsigned ZW = 14;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_done = 1'b1;
  logic          arm = 1'b0;
  logic          abort_r = 1'b0;
  logic [LW-1:0] rec_len = '0;
  logic [ZW-1:0] trig_level = '0;
  logic          trig_slope = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          adc_valid = 1'b0;
  logic          tready = 1'b1;

  logic          adc_ready;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          busy;
  logic          done;
  logic          ovf;
  logic [2:0]    state;

  adc_acq_ctrl dut (
    .i_sys_clock      (clk),
    .i_reset          (rst),
    .i_init_done      (init_done),
    .i_arm            (arm),
    .i_abort          (abort_r),
    .i_record_len     (rec_len),
    .i_trig_level     (trig_level),
    .i_trig_slope     (trig_slope),
    .i_adc_data       (adc_data),
    .i_adc_data_valid (adc_valid),
    .o_adc_ready      (adc_ready),
    .o_m_axis_tdata   (tdata),
    .o_m_axis_tvalid  (tvalid),
    .o_m_axis_tlast   (tlast),
    .i_m_axis_tready  (tready),
    .o_busy           (busy),
    .o_done           (done),
    .o_overflow       (ovf),
    .o_state          (state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model (phase 0..4 = IDLE..FLUSH) ----------------
  int          m_ph = 0;
  int          m_len = 0;
  int          m_cnt = 0;
  int          m_lvl = 0;
  int          m_prev = 0;
  bit          m_slope = 0;
  bit          m_seeded = 0;
  bit          m_vld = 0;
  bit          m_lst = 0;
  bit          m_done = 0;
  bit          m_ovf = 0;
  bit          m_abt = 0;
  logic [31:0] m_dat = '0;

  function automatic bit crosses(int prev, int cur, int lvl, bit fall);
    if (fall) return (prev > lvl) && (cur <= lvl);
    return (prev < lvl) && (cur >= lvl);
  endfunction

  always @(posedge clk) begin : model
    bit full, fire, stop, ld;
    int ch;
    if (rst) begin
      m_ph = 0; m_len = 0; m_cnt = 0; m_vld = 0; m_lst = 0; m_done = 0;
      m_ovf = 0; m_abt = 0; m_dat = '0; m_seeded = 0;
    end else begin
      full   = m_vld;
      fire   = m_vld && tready;
      ld     = 0;
      m_done = 0;
      stop   = abort_r || (!init_done && (m_ph == 2 || m_ph == 3));
      ch     = int'($signed(adc_data[31 -: ZW]));
      if (fire) begin m_vld = 0; m_lst = 0; end
      case (m_ph)
        0: if (arm && !abort_r && rec_len != 0) begin
             m_len = int'(rec_len); m_lvl = int'($signed(trig_level));
             m_slope = trig_slope; m_ovf = 0; m_cnt = 0; m_seeded = 0; m_abt = 0;
             m_ph = 1;
           end
        1: if (abort_r) m_ph = 0; else if (init_done) m_ph = 2;
        2: begin
          if (stop) m_ph = 0;
`ifdef ADC_ACQ_TRIGGER_EN
          else if (adc_valid) begin
            if (m_seeded && crosses(m_prev, ch, m_lvl, m_slope)) ld = 1;
            else begin m_prev = ch; m_seeded = 1; end
          end
`else
          else if (adc_valid) ld = 1;
          else m_ph = 3;
`endif
        end
        3: begin
          if (stop) begin
            if (full && !tready) begin m_ph = 4; m_abt = 1; end
            else m_ph = 0;
          end else if (adc_valid) begin
            if (!full || tready) ld = 1; else m_ovf = 1;
          end
        end
        4: begin
          if (abort_r) m_abt = 1;
          if (fire) begin m_ph = 0; m_done = !m_abt; end
        end
        default: m_ph = 0;
      endcase
      if (ld) begin
        m_vld = 1; m_dat = adc_data; m_cnt++;
        m_lst = (m_cnt == m_len);
        m_ph  = m_lst ? 4 : 3;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  int beat_ch[$];
  bit beat_last[$];
  int ndone = 0;
  int lit_sel = 0;
  int lit_done = 0;

  task automatic lit_beats(string nm, int n, int e0, int e1, int e2, int e3,
                           int lastpos, int nd);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({nm, "_count"}, beat_ch.size(), n);
    for (int i = 0; i < n && i < beat_ch.size(); i++) begin
      chk($sformatf("%s_beat%0d", nm, i), beat_ch[i], e[i]);
      chk($sformatf("%s_last%0d", nm, i), int'(beat_last[i]), int'(i == lastpos));
    end
    chk({nm, "_done"}, ndone, nd);
  endtask

  task automatic run_lit(int sel);
    case (sel)
`ifdef ADC_ACQ_TRIGGER_EN
      1: lit_beats("ramp", 4, 0, 10, 20, 30, 3, 1);
      2: lit_beats("stall", 4, 0, 10, 50, 60, 3, 1);
      4: lit_beats("init", 2, 5, 15, 0, 0, 1, 1);
      5: lit_beats("abort", 1, 10, 0, 0, 0, -1, 0);
      8: lit_beats("falling", 2, 50, 40, 0, 0, 1, 1);
      9: lit_beats("len1", 1, 100, 0, 0, 0, 0, 1);
      10: lit_beats("init_drop", 2, 5, 15, 0, 0, -1, 0);
`else
      1: lit_beats("ramp", 4, -100, -90, -80, -70, 3, 1);
      2: lit_beats("stall", 4, -100, -90, -50, -40, 3, 1);
      4: lit_beats("init", 2, -5, 5, 0, 0, 1, 1);
      5: lit_beats("abort", 1, -10, 0, 0, 0, -1, 0);
      8: lit_beats("falling", 2, 60, 55, 0, 0, 1, 1);
      9: lit_beats("len1", 1, -1, 0, 0, 0, 0, 1);
      10: lit_beats("init_drop", 3, -5, 5, 15, 0, -1, 0);
`endif
      3: begin
        chk("wait_init_state", int'(state), 1);
        chk("wait_init_beats", beat_ch.size(), 0);
      end
      6: begin
        chk("len0_state", int'(state), 0);
        chk("len0_busy", int'(busy), 0);
      end
      7: chk("arm_abort_state", int'(state), 0);
      default: ;
    endcase
    case (sel)
      1: chk("ramp_ovf", int'(ovf), 0);
      2: chk("stall_ovf", int'(ovf), 1);
      4: chk("init_ovf", int'(ovf), 0);
      5: chk("abort_state", int'(state), 0);
      default: ;
    endcase
  endtask

  // Per-cycle compare, beat monitor and literal checkpoints
  always @(negedge clk) begin
    chk("state", int'(state), m_ph);
    chk("busy", int'(busy), int'(m_ph != 0));
    chk("tvalid", int'(tvalid), int'(m_vld));
    chk("tdata", int'(tdata), int'(m_dat));
    if (m_vld) chk("tlast", int'(tlast), int'(m_lst));
    chk("done", int'(done), int'(m_done));
    chk("overflow", int'(ovf), int'(m_ovf));
    chk("adc_ready", int'(adc_ready), 1);
    if (lit_sel != lit_done) begin
      run_lit(lit_sel);
      lit_done = lit_sel;
      beat_ch.delete();
      beat_last.delete();
      ndone = 0;
    end
    if (tvalid && tready) begin
      beat_ch.push_back(int'($signed(tdata[31 -: ZW])));
      beat_last.push_back(tlast);
    end
    if (done) ndone++;
  end

  // ---------------- stimulus ----------------
  int seq = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, int ch, bit rdy);
    adc_data  = {ZW'(ch), 18'(seq)};
    seq++;
    adc_valid = v;
    tready    = rdy;
    tick();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b1);
  endtask

  task automatic do_arm(int len, int lvl, bit slope, bit ab);
    arm        = 1'b1;
    abort_r    = ab;
    rec_len    = LW'(len);
    trig_level = ZW'(lvl);
    trig_slope = slope;
    adc_valid  = 1'b0;
    tick();
    arm     = 1'b0;
    abort_r = 1'b0;
  endtask

  task automatic checkpoint(int sel);
    lit_sel = sel;
    idle(2);
  endtask

  initial begin
    int base;
`ifdef ADC_ACQ_TRIGGER_EN
    base = 10;
`else
    base = 0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    idle(2);

    // 1: ramp, rising through 0, free-flowing output
    do_arm(4, 0, 1'b0, 1'b0);
    idle(1);
    for (int k = 0; k < 21; k++) drive(1'b1, -100 + 10 * k, 1'b1);
    idle(4);
    checkpoint(1);

    // 2: same ramp with a 3-cycle stall mid-record
    do_arm(4, 0, 1'b0, 1'b0);
    idle(1);
    for (int k = 0; k < 21; k++)
      drive(1'b1, -100 + 10 * k, !(k >= base + 2 && k <= base + 4));
    idle(4);
    checkpoint(2);

    // 3/4: arm while init is low, then release init
    init_done = 1'b0;
    do_arm(2, 0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) drive(1'b1, 77, 1'b1);
    checkpoint(3);
    init_done = 1'b1;
    idle(1);
    drive(1'b1, -5, 1'b1);
    drive(1'b1, 5, 1'b1);
    drive(1'b1, 15, 1'b1);
    drive(1'b1, 25, 1'b1);
    idle(4);
    checkpoint(4);

    // 5: abort with a pending beat under backpressure
    do_arm(8, 0, 1'b0, 1'b0);
    idle(1);
    drive(1'b1, -10, 1'b0);
    drive(1'b1, 10, 1'b0);
    drive(1'b1, 20, 1'b0);
    abort_r = 1'b1;
    drive(1'b0, 0, 1'b0);
    abort_r = 1'b0;
    drive(1'b0, 0, 1'b0);
    drive(1'b0, 0, 1'b0);
    idle(3);
    checkpoint(5);

    // 6: zero length arm is ignored; 7: arm with abort is ignored
    do_arm(0, 0, 1'b0, 1'b0);
    idle(1);
    checkpoint(6);
    do_arm(4, 0, 1'b0, 1'b1);
    idle(1);
    checkpoint(7);

    // 8: falling slope at level 50
    do_arm(2, 50, 1'b1, 1'b0);
    idle(1);
    drive(1'b1, 60, 1'b1);
    drive(1'b1, 55, 1'b1);
    drive(1'b1, 50, 1'b1);
    drive(1'b1, 40, 1'b1);
    idle(4);
    checkpoint(8);

    // 9: single-sample record
    do_arm(1, 0, 1'b0, 1'b0);
    idle(1);
    drive(1'b1, -1, 1'b1);
    drive(1'b1, 100, 1'b1);
    idle(4);
    checkpoint(9);

    // 10: init falls during capture
    do_arm(8, 0, 1'b0, 1'b0);
    idle(1);
    drive(1'b1, -5, 1'b1);
    drive(1'b1, 5, 1'b1);
    drive(1'b1, 15, 1'b1);
    init_done = 1'b0;
    drive(1'b0, 0, 1'b1);
    init_done = 1'b1;
    idle(4);
    checkpoint(10);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_acq_ctrl.md
# adc_acq_ctrl

Acquisition sequencer between the Zmod scope controller's sample stream and the downstream AXI-Stream consumer (DMA / capture FIFO). It waits for ADC and relay init, arms on request, optionally waits for a channel-1 level crossing, then forwards exactly `i_record_len` samples as one AXIS packet terminated by TLAST. It never stalls the ADC stream: a sample that cannot be accepted downstream is dropped and flagged.

## Interface
- `ZMOD_DATA_SIZE`, default 14: ADC sample width; channel-1 sample is `i_adc_data[31 -: ZMOD_DATA_SIZE]`, two's complement.
- `AXIS_DATA_SIZE`, default 32: stream data width, in and out.
- `LEN_WIDTH`, default 16: record length counter width.
- `i_sys_clock` in 1: single clock; all logic on its rising edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_init_done` in 1: ADC and relay init complete.
- `i_arm` in 1: single-cycle arm request.
- `i_abort` in 1: single-cycle abort request.
- `i_record_len` in LEN_WIDTH: samples per record, sampled on accepted arm.
- `i_trig_level` in ZMOD_DATA_SIZE: signed trigger threshold, sampled on arm.
- `i_trig_slope` in 1: 0 = rising, 1 = falling, sampled on arm.
- `i_adc_data` in AXIS_DATA_SIZE: ADC stream data.
- `i_adc_data_valid` in 1: ADC stream valid.
- `o_adc_ready` out 1: ADC stream ready; constant 1.
- `o_m_axis_tdata` out AXIS_DATA_SIZE, `o_m_axis_tvalid` out 1, `o_m_axis_tlast` out 1, `i_m_axis_tready` in 1: output stream.
- `o_busy` out 1: state is not IDLE.
- `o_done` out 1: one-cycle pulse when the last beat of a complete record is accepted.
- `o_overflow` out 1: sticky, sample dropped during current or last record.
- `o_state` out 3: current state encoding.

## Operation
- States: IDLE=0, WAIT_INIT=1, ARMED=2, CAPTURE=3, FLUSH=4.
- IDLE: `i_arm` with `i_record_len != 0` latches length/level/slope, clears `o_overflow`, goes to WAIT_INIT. Arm with length 0 is ignored.
- WAIT_INIT: goes to ARMED on the first cycle `i_init_done` = 1.
- ARMED: tracks the previous valid ch1 sample. Rising trigger: prev < level and cur >= level (signed). Falling: prev > level and cur <= level. The first valid sample after arming only seeds prev. The triggering sample is the first captured sample; go to CAPTURE.
- CAPTURE: each valid input sample loads the output register if it is empty or is being accepted this cycle; otherwise the sample is dropped and `o_overflow` is set. The count increments only on loaded samples. The load of sample number `record_len` sets tlast and moves to FLUSH.
- FLUSH: holds until the pending beat is accepted, then goes to IDLE. `o_done` pulses only for a complete record.
- Abort, or `i_init_done` falling in ARMED/CAPTURE: stop loading samples. A pending beat is held (AXIS rule) until accepted, without forcing tlast. Then go to IDLE, with no `o_done`. Abort in WAIT_INIT/ARMED goes to IDLE the next cycle.
- Arm while busy is ignored. Arm and abort in the same cycle: abort wins.
- tdata passes through unmodified, both channels.

## Timing
- Reset values: state IDLE, tvalid/tlast/done/overflow/busy = 0, tdata = 0, count = 0, `o_adc_ready` = 1.
- Latency: input sample to `o_m_axis_tvalid` is 1 cycle, registered.
- Trigger: the crossing sample appears at the output 1 cycle after it is presented in ARMED.
- Once asserted, tvalid, tdata and tlast are stable until tready.
- Full throughput: with tready held at 1, one beat per valid input, no drops.
- The counter does not wrap: a maximum length of 2^LEN_WIDTH−1 is supported.
- `o_done` is asserted the cycle after the final handshake, coincident with state IDLE.

## Configuration
- `ADC_ACQ_TRIGGER_EN` defined: level trigger as described. `i_trig_level` and `i_trig_slope` are used.
- `ADC_ACQ_TRIGGER_EN` undefined: ARMED is passed through in one cycle, and capture starts with the first valid sample after init. The trigger inputs are unused, and the comparator and prev register are not built.

## Test plan
- Arm with len=4 and init_done=1, ramp ch1 −100..+100 step 10, level 0, rising, tready=1 → beats 0,10,20,30, tlast on 30, `o_done` pulse, state IDLE.
- Same stimulus with tready low for 3 cycles mid-record → value held stable, `o_overflow`=1, exactly 4 beats with tlast on the 4th.
- Arm with init_done=0 for 10 cycles → state stays WAIT_INIT; no beats until init_done rises.
- Abort while in CAPTURE with a pending beat and tready=0 → beat held, then accepted, tlast=0, no `o_done`, IDLE.
- Arm with len=0 → state stays IDLE. Arm+abort in the same cycle → state stays IDLE.
- Falling slope, level 50, ch1 sequence 60,55,50,40 → first beat is 50. Macro undefined → first beat is 60.
